// File: rtl/alu_exec_sequencer_if.sv
// Signal bundle linking the execute sequencer to the decoder, the ALU,
// the load write-back requester and the register-file write port.
interface alu_exec_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_v1;
  logic [31:0] in_v2;
  logic        in_wb_flag;
  logic [7:0]  in_wb_code;
  logic [4:0]  alu_op;
  logic [31:0] alu_v1;
  logic [31:0] alu_v2;
  logic [31:0] alu_result;
  logic        mem_wb_valid;
  logic [7:0]  mem_wb_code;
  logic [31:0] mem_wb_data;
  logic        mem_wb_ready;
  logic        rf_we;
  logic [7:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  modport slave (
    input  in_valid, in_op, in_v1, in_v2, in_wb_flag, in_wb_code,
    input  alu_result, mem_wb_valid, mem_wb_code, mem_wb_data,
    output in_ready, alu_op, alu_v1, alu_v2, mem_wb_ready,
    output rf_we, rf_waddr, rf_wdata, busy
  );

  modport master (
    output in_valid, in_op, in_v1, in_v2, in_wb_flag, in_wb_code,
    output alu_result, mem_wb_valid, mem_wb_code, mem_wb_data,
    input  in_ready, alu_op, alu_v1, alu_v2, mem_wb_ready,
    input  rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer: holds one decoded op on the ALU for its latency,
// then arbitrates its write-back against load write-backs with bounded deferral.
module alu_exec_sequencer #(
  parameter int unsigned LAT_MUL   = 4,
  parameter int unsigned LAT_DIV   = 16,
  parameter int unsigned MAX_DEFER = 3
) (
  input logic                 clk,
  input logic                 reset,
  alu_exec_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_e;

  localparam logic [7:0] MUL_CNT     = 8'(LAT_MUL - 1);
  localparam logic [7:0] DIV_CNT     = 8'(LAT_DIV - 1);
  localparam logic [3:0] DEFER_LIMIT = 4'(MAX_DEFER);

  state_e      state_q, state_d;
  logic [7:0]  counter_q, counter_d;
  logic [3:0]  deferCnt_q, deferCnt_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] v1_q, v1_d;
  logic [31:0] v2_q, v2_d;
  logic [31:0] res_q, res_d;
  logic        wbFlag_q, wbFlag_d;
  logic [7:0]  wbCode_q, wbCode_d;
  logic        rfWe_q, rfWe_d;
  logic [7:0]  rfWaddr_q, rfWaddr_d;
  logic [31:0] rfWdata_q, rfWdata_d;
  logic        memReady;
  logic        aluGrant;
  logic [7:0]  startCnt;

  always_comb begin
    unique case (bus.in_op)
      5'b00011:          startCnt = MUL_CNT;
      5'b00100, 5'b00101: startCnt = DIV_CNT;
      default:           startCnt = 8'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    deferCnt_d = deferCnt_q;
    op_d       = op_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    res_d      = res_q;
    wbFlag_d   = wbFlag_q;
    wbCode_d   = wbCode_q;
    rfWe_d     = 1'b0;
    rfWaddr_d  = rfWaddr_q;
    rfWdata_d  = rfWdata_q;
    memReady   = 1'b1;
    aluGrant   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d     = bus.in_op;
          v1_d     = bus.in_v1;
          v2_d     = bus.in_v2;
          wbFlag_d = bus.in_wb_flag;
          wbCode_d = bus.in_wb_code;
          if (bus.in_op != 5'd0) begin
            counter_d = startCnt;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        if (counter_q == 8'd0) begin
          res_d   = bus.alu_result;
          state_d = wbFlag_q ? WB : IDLE;
        end else begin
          counter_d = counter_q - 8'd1;
        end
      end
      WB: begin
        // Loads win until they have starved the pending ALU result DEFER_LIMIT times.
        if (bus.mem_wb_valid && (deferCnt_q < DEFER_LIMIT)) begin
          deferCnt_d = deferCnt_q + 4'd1;
        end else begin
          memReady   = 1'b0;
          aluGrant   = 1'b1;
          deferCnt_d = 4'd0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.mem_wb_valid && memReady) begin
      rfWe_d    = 1'b1;
      rfWaddr_d = bus.mem_wb_code;
      rfWdata_d = bus.mem_wb_data;
    end else if (aluGrant) begin
      rfWe_d    = 1'b1;
      rfWaddr_d = wbCode_q;
      rfWdata_d = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      counter_q  <= 8'd0;
      deferCnt_q <= 4'd0;
      op_q       <= 5'd0;
      v1_q       <= 32'd0;
      v2_q       <= 32'd0;
      res_q      <= 32'd0;
      wbFlag_q   <= 1'b0;
      wbCode_q   <= 8'd0;
      rfWe_q     <= 1'b0;
      rfWaddr_q  <= 8'd0;
      rfWdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      deferCnt_q <= deferCnt_d;
      op_q       <= op_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      res_q      <= res_d;
      wbFlag_q   <= wbFlag_d;
      wbCode_q   <= wbCode_d;
      rfWe_q     <= rfWe_d;
      rfWaddr_q  <= rfWaddr_d;
      rfWdata_q  <= rfWdata_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.mem_wb_ready = memReady;
  assign bus.alu_op       = (state_q == EXEC) ? op_q : 5'd0;
  assign bus.alu_v1       = (state_q == EXEC) ? v1_q : 32'd0;
  assign bus.alu_v2       = (state_q == EXEC) ? v2_q : 32'd0;
  assign bus.rf_we        = rfWe_q;
  assign bus.rf_waddr     = rfWaddr_q;
  assign bus.rf_wdata     = rfWdata_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Randomized scoreboard bench for alu_exec_sequencer with a transaction-level
// model of op occupancy and write-port arbitration.
module tb_alu_exec_sequencer;
  localparam int LAT_MUL   = 4;
  localparam int LAT_DIV   = 16;
  localparam int MAX_DEFER = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_exec_sequencer_if bus();

  alu_exec_sequencer #(
    .LAT_MUL  (LAT_MUL),
    .LAT_DIV  (LAT_DIV),
    .MAX_DEFER(MAX_DEFER)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Stand-in ALU whose result depends on all of opcode and operands.
  function automatic logic [31:0] aluFn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a * b;
      5'd4:    return (sb == 0) ? 32'd0 : 32'(sa / sb);
      5'd5:    return (sb == 0) ? 32'd0 : 32'(sa % sb);
      default: return a ^ b;
    endcase
  endfunction

  assign bus.alu_result = aluFn(bus.alu_op, bus.alu_v1, bus.alu_v2);

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t expQ[$];
  int  cycleNo = 0;
  int  checkCount = 0;
  int  passCount = 0;

  // Model: remaining ALU-holding cycles, whether a result still needs the write port.
  int          execLeft = 0;
  bit          pend = 1'b0;
  int          defers = 0;
  logic [4:0]  mOp = '0;
  logic [31:0] mV1 = '0;
  logic [31:0] mV2 = '0;
  logic [31:0] mRes = '0;
  logic [7:0]  mCode = '0;

  always @(posedge clk) cycleNo++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cycleNo, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("rf_we_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = expQ.pop_front();
        checkOutput("rf_cycle", cycleNo, w.cyc);
        checkOutput("rf_waddr", {24'd0, bus.rf_waddr}, {24'd0, w.addr});
        checkOutput("rf_wdata", bus.rf_wdata, w.data);
      end
    end else if (expQ.size() != 0 && expQ[0].cyc == cycleNo) begin
      checkOutput("rf_we_missing", {31'd0, bus.rf_we}, 32'd1);
      void'(expQ.pop_front());
    end
  end

  // Called #1 after a rising edge; drives one cycle, checks it, advances the model.
  task automatic applyStimulus(input bit iv, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit wf, input logic [7:0] wc,
                               input bit mv, input logic [7:0] mc, input logic [31:0] md);
    bit  idle, inWb, memWins;
    int  lat;
    wr_t w;
    bus.in_valid     = iv;
    bus.in_op        = op;
    bus.in_v1        = a;
    bus.in_v2        = b;
    bus.in_wb_flag   = wf;
    bus.in_wb_code   = wc;
    bus.mem_wb_valid = mv;
    bus.mem_wb_code  = mc;
    bus.mem_wb_data  = md;
    idle    = (execLeft == 0) && !pend;
    inWb    = pend && (execLeft == 0);
    memWins = mv && (!inWb || defers < MAX_DEFER);
    @(negedge clk);
    checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, idle});
    checkOutput("busy", {31'd0, bus.busy}, {31'd0, !idle});
    checkOutput("mem_wb_ready", {31'd0, bus.mem_wb_ready}, {31'd0, (!inWb || memWins)});
    checkOutput("alu_op", {27'd0, bus.alu_op}, (execLeft > 0) ? {27'd0, mOp} : 32'd0);
    checkOutput("alu_v1", bus.alu_v1, (execLeft > 0) ? mV1 : 32'd0);
    checkOutput("alu_v2", bus.alu_v2, (execLeft > 0) ? mV2 : 32'd0);
    if (memWins) begin
      w.cyc = cycleNo + 1; w.addr = mc; w.data = md;
      expQ.push_back(w);
    end
    if (inWb) begin
      if (memWins) defers++;
      else begin
        w.cyc = cycleNo + 1; w.addr = mCode; w.data = mRes;
        expQ.push_back(w);
        pend = 1'b0;
        defers = 0;
      end
    end
    if (execLeft > 0) execLeft--;
    if (idle && iv && op != 5'd0) begin
      lat = (op == 5'd3) ? LAT_MUL : ((op == 5'd4 || op == 5'd5) ? LAT_DIV : 1);
      execLeft = lat;
      pend  = wf;
      mOp   = op;
      mV1   = a;
      mV2   = b;
      mCode = wc;
      mRes  = aluFn(op, a, b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 5'd0, 0, 0, 0, 8'd0, 0, 8'd0, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_v1 = '0; bus.in_v2 = '0;
    bus.in_wb_flag = 1'b0; bus.in_wb_code = '0;
    bus.mem_wb_valid = 1'b0; bus.mem_wb_code = '0; bus.mem_wb_data = '0;
    @(posedge clk);
    #1;
    checkOutput("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    checkOutput("rst_rf_waddr", {24'd0, bus.rf_waddr}, 32'd0);
    checkOutput("rst_rf_wdata", bus.rf_wdata, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_alu_op", {27'd0, bus.alu_op}, 32'd0);
    checkOutput("rst_alu_v1", bus.alu_v1, 32'd0);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    reset = 1'b0;
    execLeft = 0; pend = 1'b0; defers = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] opTab [10];
    int bias;
    opTab = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd31};

    doReset();

    // ADD 5+7 to r3: write lands three cycles after accept.
    applyStimulus(1, 5'd1, 32'd5, 32'd7, 1, 8'h03, 0, 8'd0, 32'd0);
    idleCycles(4);

    // DIV 100/7 with another op held on in_valid the whole time.
    applyStimulus(1, 5'd4, 32'd100, 32'd7, 1, 8'h21, 0, 8'd0, 32'd0);
    for (int i = 0; i < 18; i++) applyStimulus(1, 5'd1, 32'd1, 32'd2, 1, 8'h55, 0, 8'd0, 32'd0);
    idleCycles(4);

    // SUB in WB against a continuous stream of load writes.
    applyStimulus(1, 5'd2, 32'd50, 32'd8, 1, 8'h44, 0, 8'd0, 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 5'd0, 0, 0, 0, 8'd0, 1, 8'(8'h60 + i), $urandom);
    idleCycles(3);

    // Dropped op 0, then SUB without write-back.
    applyStimulus(1, 5'd0, 32'd9, 32'd9, 1, 8'h12, 0, 8'd0, 32'd0);
    idleCycles(2);
    applyStimulus(1, 5'd2, 32'd9, 32'd4, 0, 8'h13, 0, 8'd0, 32'd0);
    idleCycles(3);

    // Reset in the middle of a DIV.
    applyStimulus(1, 5'd4, 32'd1000, 32'd3, 1, 8'h77, 0, 8'd0, 32'd0);
    idleCycles(4);
    doReset();
    idleCycles(20);

    // Load write coinciding with an ALU accept.
    applyStimulus(1, 5'd3, 32'd6, 32'd7, 1, 8'h05, 1, 8'h0A, 32'hDEADBEEF);
    idleCycles(8);

    for (int seg = 0; seg < 6; seg++) begin
      bias = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 300; i++) begin
        applyStimulus($urandom_range(0, 1) == 1, opTab[$urandom_range(0, 9)], $urandom,
                      32'($urandom_range(1, 5000)), $urandom_range(0, 3) != 0, 8'($urandom),
                      $urandom_range(0, 99) < bias, 8'($urandom), $urandom);
      end
    end

    for (int i = 0; i < 100 && (execLeft != 0 || pend); i++) idleCycles(1);
    idleCycles(3);
    checkOutput("pending_writes", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
